// File: rtl/csa_acc.sv
// Carry-save accumulator: one operand per cycle into redundant sum/carry vectors,
// then a chunked carry-propagate resolve before presenting the result.
module csa_acc #(
    parameter int WID  = 32,
    parameter int AWID = 40,
    parameter int CHK  = 8,
    parameter int SGN  = 1,
    parameter int CWID = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_vld,
    output logic            in_rdy,
    input  logic [WID-1:0]  in_dat,
    input  logic            in_sub,
    input  logic            in_last,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [AWID-1:0] out_dat,
    output logic [CWID-1:0] out_cnt
);
    localparam int NCHK = AWID / CHK;
    localparam int IWID = (NCHK > 1) ? $clog2(NCHK) : 1;

    typedef enum logic [1:0] {ACC, RES, OUT} state_t;

    state_t                     state_q, state_d;
    logic [AWID-1:0]            s_q, s_d, c_q, c_d;
    logic [NCHK-1:0][CHK-1:0]   res_q, res_d;
    logic [IWID-1:0]            idx_q, idx_d;
    logic                       cy_q, cy_d;
    logic [CWID-1:0]            cnt_q, cnt_d;
    logic                       out_vld_q, out_vld_d;

    logic [AWID-1:0]            x_ext, x_op, maj;
    logic [NCHK-1:0][CHK-1:0]   s_chk, c_chk;
    logic [CHK:0]               sum;
    logic                       accept, handshake;

    assign s_chk = s_q;
    assign c_chk = c_q;

    // Extend, then invert for subtraction; the +1 rides in the carry vector's bit 0.
    always_comb begin
        if (SGN != 0) begin
            x_ext = {{(AWID-WID){in_dat[WID-1]}}, in_dat};
        end else begin
            x_ext = {{(AWID-WID){1'b0}}, in_dat};
        end
        x_op = x_ext ^ {AWID{in_sub}};
        maj  = (s_q & c_q) | (s_q & x_op) | (c_q & x_op);
    end

    assign sum       = {1'b0, s_chk[idx_q]} + {1'b0, c_chk[idx_q]} + {{CHK{1'b0}}, cy_q};
    assign accept    = in_vld && (state_q == ACC);
    assign handshake = out_vld_q && out_rdy;

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        c_d       = c_q;
        res_d     = res_q;
        idx_d     = idx_q;
        cy_d      = cy_q;
        cnt_d     = cnt_q;
        out_vld_d = 1'b0;
        case (state_q)
            ACC: begin
                if (accept) begin
                    s_d   = s_q ^ c_q ^ x_op;
                    c_d   = {maj[AWID-2:0], in_sub};
                    cnt_d = (cnt_q == {CWID{1'b1}}) ? cnt_q : cnt_q + 1'b1;
                    if (in_last) begin
                        state_d = RES;
                        idx_d   = '0;
                        cy_d    = 1'b0;
                    end
                end
            end
            RES: begin
                res_d[idx_q] = sum[CHK-1:0];
                cy_d         = sum[CHK];
                idx_d        = idx_q + 1'b1;
                if (idx_q == IWID'(NCHK - 1)) begin
                    state_d = OUT;
                    idx_d   = '0;
                end
            end
            OUT: begin
                // Valid rises one cycle after the final chunk lands.
                out_vld_d = 1'b1;
                if (handshake) begin
                    state_d   = ACC;
                    s_d       = '0;
                    c_d       = '0;
                    res_d     = '0;
                    cnt_d     = '0;
                    out_vld_d = 1'b0;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACC;
            s_q       <= '0;
            c_q       <= '0;
            res_q     <= '0;
            idx_q     <= '0;
            cy_q      <= 1'b0;
            cnt_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            c_q       <= c_d;
            res_q     <= res_d;
            idx_q     <= idx_d;
            cy_q      <= cy_d;
            cnt_q     <= cnt_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign in_rdy  = (state_q == ACC);
    assign out_vld = out_vld_q;
    assign out_dat = out_vld_q ? res_q : '0;
    assign out_cnt = cnt_q;
endmodule
